// File: rtl/interboard_tx_scheduler_if.sv
// Interface bundling the request ports and the link handshake of
// interboard_tx_scheduler. The "master" modport is the scheduler side: it
// takes requests and drives the link. The "slave" modport is the
// environment side: it issues requests and answers with tx_ready.
interface interboard_tx_scheduler_if;
  logic       sys_en;
  logic [2:0] sys_msg_type;
  logic [4:0] sys_number;
  logic       ctrl_en;
  logic [2:0] ctrl_msg_type;
  logic [4:0] ctrl_number;
  logic       tx_ready;
  logic       tx_valid;
  logic [2:0] tx_msg_type;
  logic [4:0] tx_number;

  modport master (
    input  sys_en, sys_msg_type, sys_number,
    input  ctrl_en, ctrl_msg_type, ctrl_number,
    input  tx_ready,
    output tx_valid, tx_msg_type, tx_number
  );

  modport slave (
    output sys_en, sys_msg_type, sys_number,
    output ctrl_en, ctrl_msg_type, ctrl_number,
    output tx_ready,
    input  tx_valid, tx_msg_type, tx_number
  );
endinterface

// File: rtl/interboard_tx_scheduler.sv
// interboard_tx_scheduler: sequences outbound inter-board messages onto one
// link transmitter. System messages (one-entry slot, newest wins) take
// priority over game messages (FIFO). Each message is presented with a
// valid/ready handshake and is followed by a forced idle gap.
// Optional feature: define INTERBOARD_TX_TIMEOUT_EN to abandon a message
// that waits TIMEOUT_CYCLES in SEND without tx_ready (tx_timeout pulses).
// Without the macro SEND waits indefinitely and tx_timeout is tied to 0.
module interboard_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               interboard_rst,
  interboard_tx_scheduler_if.master          bus,
  output logic                               transmit,
  output logic                               game_full,
  output logic [7:0]                         drop_cnt,
  output logic                               tx_timeout
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD      = GAP_W'(GAP_CYCLES);

  // Reject configurations the pointer arithmetic and gap counter cannot handle.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("interboard_tx_scheduler: illegal parameter combination");
  end

  typedef struct packed {
    logic [2:0] msg_type;
    logic [4:0] number;
  } msg_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Local and remote resets have identical effect.
  logic reset_all;
  assign reset_all = rst | interboard_rst;

  state_e            state_q;
  msg_t              fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              slot_valid_q, slot_valid_d;
  msg_t              slot_q;
  logic [7:0]        drop_cnt_q;
  logic              game_full_q;
  logic              transmit_q;
  logic              tx_valid_q;
  msg_t              tx_msg_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic              timeout_hit;

  logic fifo_empty, fifo_full;
  logic sel_sys, sel_fifo, push_ok, push_drop, pending_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL_CNT);

  // The sys slot always wins arbitration in IDLE; the selected entry is
  // consumed in the same cycle it is latched into the tx registers.
  assign sel_sys   = (state_q == ST_IDLE) && slot_valid_q;
  assign sel_fifo  = (state_q == ST_IDLE) && !slot_valid_q && !fifo_empty;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok   = bus.ctrl_en && (!fifo_full || sel_fifo);
  assign push_drop = bus.ctrl_en && fifo_full && !sel_fifo;

  // Next occupancy of the FIFO and the sys slot.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    count_d      = count_q;
    slot_valid_d = slot_valid_q;
    if (push_ok && !sel_fifo) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_ok && sel_fifo) begin
      count_d = count_q - CNT_W'(1);
    end
    if (bus.sys_en) begin
      slot_valid_d = 1'b1;
    end else if (sel_sys) begin
      slot_valid_d = 1'b0;
    end
  end

  assign pending_d = slot_valid_d | (count_d != '0);

  // FIFO pointers, sys slot, drop counter and full flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset_all) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      slot_valid_q <= 1'b0;
      slot_q       <= '0;
      drop_cnt_q   <= '0;
      game_full_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      game_full_q  <= (count_d == FIFO_FULL_CNT);
      slot_valid_q <= slot_valid_d;
      if (bus.sys_en) begin
        slot_q <= {bus.sys_msg_type, bus.sys_number};
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (sel_fifo) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_drop && drop_cnt_q != 8'hFF) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // FIFO storage writes.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the reset pointers and count
    // make stale entries unreachable, and the array maps onto plain RAM.
    if (push_ok) begin
      fifo_mem_q[wr_ptr_q] <= {bus.ctrl_msg_type, bus.ctrl_number};
    end
  end

  // Transmit FSM: IDLE selects, SEND handshakes, GAP enforces spacing.
  always_ff @(posedge clk) begin
    if (reset_all) begin
      state_q    <= ST_IDLE;
      tx_valid_q <= 1'b0;
      tx_msg_q   <= '0;
      gap_cnt_q  <= '0;
      transmit_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel_sys) begin
            tx_msg_q   <= slot_q;
            tx_valid_q <= 1'b1;
            transmit_q <= 1'b1;
            state_q    <= ST_SEND;
          end else if (sel_fifo) begin
            tx_msg_q   <= fifo_mem_q[rd_ptr_q];
            tx_valid_q <= 1'b1;
            transmit_q <= 1'b1;
            state_q    <= ST_SEND;
          end else begin
            transmit_q <= pending_d;
          end
        end
        ST_SEND: begin
          transmit_q <= 1'b1;
          if (bus.tx_ready || timeout_hit) begin
            tx_valid_q <= 1'b0;
            gap_cnt_q  <= GAP_LOAD;
            state_q    <= ST_GAP;
          end
        end
        ST_GAP: begin
          // The count runs GAP_CYCLES..0, so an accept in cycle N lets the
          // next message appear at N+1+GAP_CYCLES+2.
          if (gap_cnt_q == '0) begin
            transmit_q <= pending_d;
            state_q    <= ST_IDLE;
          end else begin
            gap_cnt_q  <= gap_cnt_q - GAP_W'(1);
            transmit_q <= 1'b1;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INTERBOARD_TX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            tx_timeout_q;

  assign timeout_hit = (state_q == ST_SEND) && !bus.tx_ready && (to_cnt_q == TO_LAST);

  // Wait counter: zero outside SEND so it restarts on every SEND entry.
  always_ff @(posedge clk) begin
    if (reset_all) begin
      to_cnt_q     <= '0;
      tx_timeout_q <= 1'b0;
    end else begin
      tx_timeout_q <= timeout_hit;
      if (state_q == ST_SEND) begin
        to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  assign tx_timeout = tx_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign tx_timeout  = 1'b0;
`endif

  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_msg_type = tx_msg_q.msg_type;
  assign bus.tx_number   = tx_msg_q.number;
  assign transmit        = transmit_q;
  assign game_full       = game_full_q;
  assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_interboard_tx_scheduler.sv
// Directed bench for interboard_tx_scheduler. Expected link transfers are
// pushed to a scoreboard queue when requests are driven and popped by a
// monitor when the DUT completes a handshake. Build with
// INTERBOARD_TX_TIMEOUT_EN defined to exercise the timeout path.
module tb_interboard_tx_scheduler;

  localparam int unsigned TIMEOUT_CYCLES = 16;

  typedef struct packed {
    logic [2:0] msg_type;
    logic [4:0] number;
  } msg_t;

  logic       clk;
  logic       rst;
  logic       interboard_rst;
  logic       transmit;
  logic       game_full;
  logic [7:0] drop_cnt;
  logic       tx_timeout;

  interboard_tx_scheduler_if bus ();

  interboard_tx_scheduler #(
    .FIFO_DEPTH     (4),
    .GAP_CYCLES     (8),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .interboard_rst (interboard_rst),
    .bus            (bus),
    .transmit       (transmit),
    .game_full      (game_full),
    .drop_cnt       (drop_cnt),
    .tx_timeout     (tx_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cmp_cnt  = 0;
  int   err_cnt  = 0;
  int   xfer_cnt = 0;
  msg_t exp_q [$];

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    cmp_cnt++;
    assert (observed === expected)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a handshake seen at the falling edge completes on the next rise.
  always @(negedge clk) begin
    if (!rst && !interboard_rst && bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      xfer_cnt++;
      check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        msg_t e;
        e = exp_q.pop_front();
        check("xfer_type", 32'(bus.tx_msg_type), 32'(e.msg_type));
        check("xfer_number", 32'(bus.tx_number), 32'(e.number));
      end
    end
  end

  task automatic drive_ctrl(input logic [2:0] t, input logic [4:0] n, input bit expect_sent);
    bus.ctrl_en       = 1'b1;
    bus.ctrl_msg_type = t;
    bus.ctrl_number   = n;
    if (expect_sent) exp_q.push_back({t, n});
  endtask

  // Bounded wait for the scoreboard to drain and the block to go quiet.
  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(transmit === 1'b0 && exp_q.size() == 0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(n >= budget), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   xfer_base;
    int   pulses;
    int   pulse_k;
    logic saw_timeout;

    rst               = 1'b1;
    interboard_rst    = 1'b0;
    bus.sys_en        = 1'b0;
    bus.sys_msg_type  = '0;
    bus.sys_number    = '0;
    bus.ctrl_en       = 1'b0;
    bus.ctrl_msg_type = '0;
    bus.ctrl_number   = '0;
    bus.tx_ready      = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_type", 32'(bus.tx_msg_type), 32'd0);
    check("rst_tx_number", 32'(bus.tx_number), 32'd0);
    check("rst_transmit", 32'(transmit), 32'd0);
    check("rst_game_full", 32'(game_full), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_tx_timeout", 32'(tx_timeout), 32'd0);
    rst = 1'b0;
    tick();

    // 1) Single game message: two-cycle latency, gap, then quiet.
    bus.tx_ready = 1'b1;
    drive_ctrl(3'd2, 5'd17, 1'b1);
    tick();
    bus.ctrl_en = 1'b0;
    check("t1_c1_valid", 32'(bus.tx_valid), 32'd0);
    check("t1_c1_transmit", 32'(transmit), 32'd1);
    tick();
    check("t1_c2_valid", 32'(bus.tx_valid), 32'd1);
    check("t1_c2_type", 32'(bus.tx_msg_type), 32'd2);
    check("t1_c2_number", 32'(bus.tx_number), 32'd17);
    tick();
    check("t1_c3_valid", 32'(bus.tx_valid), 32'd0);
    repeat (8) tick();
    check("t1_c11_transmit", 32'(transmit), 32'd1);
    tick();
    check("t1_c12_transmit", 32'(transmit), 32'd0);
    check("t1_hold_type", 32'(bus.tx_msg_type), 32'd2);

    // 2) Same-cycle sys and game request: sys first, game N+1+GAP+2 later.
    bus.sys_en       = 1'b1;
    bus.sys_msg_type = 3'd1;
    bus.sys_number   = 5'd0;
    exp_q.push_back({3'd1, 5'd0});
    drive_ctrl(3'd5, 5'd9, 1'b1);
    tick();
    bus.sys_en  = 1'b0;
    bus.ctrl_en = 1'b0;
    tick();
    check("t2_sys_valid", 32'(bus.tx_valid), 32'd1);
    check("t2_sys_type", 32'(bus.tx_msg_type), 32'd1);
    check("t2_sys_number", 32'(bus.tx_number), 32'd0);
    repeat (10) tick();
    check("t2_gap_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    check("t2_game_valid", 32'(bus.tx_valid), 32'd1);
    check("t2_game_type", 32'(bus.tx_msg_type), 32'd5);
    check("t2_game_number", 32'(bus.tx_number), 32'd9);
    wait_idle("t2_drain", 100);

    // 3) Stalled link: fill FIFO, drop one, push+pop while full, drain in order.
    bus.tx_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive_ctrl(3'd3, 5'(i), i <= 5);
      tick();
    end
    bus.ctrl_en = 1'b0;
    check("t3_full", 32'(game_full), 32'd1);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd1);
    check("t3_hold_valid", 32'(bus.tx_valid), 32'd1);
    check("t3_hold_number", 32'(bus.tx_number), 32'd1);
    xfer_base    = xfer_cnt;
    bus.tx_ready = 1'b1;
    repeat (10) tick();
    check("t3_full_before_pop", 32'(game_full), 32'd1);
    drive_ctrl(3'd3, 5'd7, 1'b1);
    tick();
    bus.ctrl_en = 1'b0;
    check("t3_full_after_pushpop", 32'(game_full), 32'd1);
    check("t3_no_extra_drop", 32'(drop_cnt), 32'd1);
    wait_idle("t3_drain", 200);
    check("t3_xfers", 32'(xfer_cnt - xfer_base), 32'd6);
    check("t3_empty", 32'(game_full), 32'd0);

    // 4) Three stalled SEND cycles, accept on the fourth.
    bus.tx_ready = 1'b0;
    xfer_base    = xfer_cnt;
    drive_ctrl(3'd6, 5'd30, 1'b1);
    tick();
    bus.ctrl_en = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_stall_valid", 32'(bus.tx_valid), 32'd1);
      check("t4_stall_msg", 32'({bus.tx_msg_type, bus.tx_number}), 32'({3'd6, 5'd30}));
      tick();
    end
    bus.tx_ready = 1'b1;
    check("t4_accept_valid", 32'(bus.tx_valid), 32'd1);
    tick();
    check("t4_after_valid", 32'(bus.tx_valid), 32'd0);
    wait_idle("t4_drain", 100);
    check("t4_one_send", 32'(xfer_cnt - xfer_base), 32'd1);

    // 5) Remote reset mid-SEND with two queued; ctrl_en during reset ignored.
    bus.tx_ready = 1'b0;
    drive_ctrl(3'd4, 5'd11, 1'b0);
    tick();
    drive_ctrl(3'd4, 5'd12, 1'b0);
    tick();
    drive_ctrl(3'd4, 5'd13, 1'b0);
    tick();
    interboard_rst = 1'b1;
    drive_ctrl(3'd4, 5'd14, 1'b0);
    tick();
    interboard_rst = 1'b0;
    bus.ctrl_en    = 1'b0;
    check("t5_valid", 32'(bus.tx_valid), 32'd0);
    check("t5_transmit", 32'(transmit), 32'd0);
    check("t5_game_full", 32'(game_full), 32'd0);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t5_tx_number", 32'(bus.tx_number), 32'd0);
    xfer_base    = xfer_cnt;
    bus.tx_ready = 1'b1;
    repeat (20) tick();
    check("t5_no_sends", 32'(xfer_cnt - xfer_base), 32'd0);
    check("t5_quiet", 32'(transmit), 32'd0);

    // 6) Long stall: timeout behaviour depends on the build.
    bus.tx_ready = 1'b0;
`ifdef INTERBOARD_TX_TIMEOUT_EN
    drive_ctrl(3'd7, 5'd31, 1'b0);
    tick();
    bus.ctrl_en = 1'b0;
    tick();
    pulses  = 0;
    pulse_k = 0;
    for (int k = 1; k <= 24; k++) begin
      tick();
      if (tx_timeout === 1'b1) begin
        pulses++;
        pulse_k = k;
        check("t6_gap_after_timeout", 32'(bus.tx_valid), 32'd0);
      end
    end
    check("t6_pulse_count", 32'(pulses), 32'd1);
    check("t6_pulse_cycle", 32'(pulse_k), 32'(TIMEOUT_CYCLES));
    wait_idle("t6_drain", 100);
    saw_timeout = 1'b0;
    check("t6_no_spurious", 32'(saw_timeout), 32'(tx_timeout));
`else
    drive_ctrl(3'd7, 5'd31, 1'b1);
    tick();
    bus.ctrl_en = 1'b0;
    tick();
    saw_timeout = 1'b0;
    pulses      = 0;
    pulse_k     = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (tx_timeout !== 1'b0) saw_timeout = 1'b1;
    end
    check("t6_no_timeout", 32'(saw_timeout), 32'd0);
    check("t6_still_valid", 32'(bus.tx_valid), 32'd1);
    bus.tx_ready = 1'b1;
    wait_idle("t6_drain", 100);
`endif
    check("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
